// File: rtl/fb_rect_writer.sv
// fb_rect_writer: rectangle-fill pixel generator feeding the SDRAM WR1 write FIFO.
// Accepts fill commands on a valid/ready handshake and emits one framebuffer
// write per non-stalled cycle in row-major order. The rectangle is clipped at
// the right and bottom framebuffer edges and never wraps.
// Optional feature: define FB_CLEAR_EN to add the iCLEAR full-screen clear,
// which starts on the next iFRAME_SYNC and writes every address with CLEAR_COLOR.
module fb_rect_writer #(
  parameter int          FB_W_LOG2   = 8,
  parameter int          FB_H_LOG2   = 8,
  parameter logic [14:0] CLEAR_COLOR = 15'h0000,
  parameter int          WAIT_FRAME  = 0
) (
  input  logic                           iCLK,
  input  logic                           iRST,
  input  logic                           iCMD_VALID,
  output logic                           oCMD_READY,
  input  logic [FB_W_LOG2-1:0]           iCMD_X0,
  input  logic [FB_H_LOG2-1:0]           iCMD_Y0,
  input  logic [FB_W_LOG2:0]             iCMD_W,
  input  logic [FB_H_LOG2:0]             iCMD_H,
  input  logic [14:0]                    iCMD_COLOR,
`ifdef FB_CLEAR_EN
  input  logic                           iCLEAR,
`endif
  input  logic                           iFRAME_SYNC,
  input  logic                           iWR_FULL,
  output logic                           oWR,
  output logic [FB_H_LOG2+FB_W_LOG2-1:0] oWR_ADDR,
  output logic [15:0]                    oWR_DATA,
  output logic                           oBUSY,
  output logic                           oDONE
);

  // Extents are formed two bits wider than a coordinate so X0+W never wraps.
  localparam int XE_W = FB_W_LOG2 + 2;
  localparam int YE_W = FB_H_LOG2 + 2;
  localparam logic [XE_W-1:0] X_LIM = XE_W'(1) << FB_W_LOG2;
  localparam logic [YE_W-1:0] Y_LIM = YE_W'(1) << FB_H_LOG2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SYNC,
    DRAW,
    DONE
`ifdef FB_CLEAR_EN
    ,
    CLR_WAIT,
    CLEAR
`endif
  } state_t;

  state_t                 state;
  logic                   ready_q;

  // Captured command and pixel walker.
  logic [FB_W_LOG2-1:0]   cmd_x0;
  logic [FB_H_LOG2-1:0]   cmd_y0;
  logic [FB_W_LOG2:0]     cmd_w;
  logic [FB_H_LOG2:0]     cmd_h;
  logic [14:0]            cmd_color;
  logic [FB_W_LOG2-1:0]   x_cur;
  logic [FB_H_LOG2-1:0]   y_cur;
  logic [FB_W_LOG2-1:0]   x_last;
  logic [FB_H_LOG2-1:0]   y_last;

  // Clipped last column/row: X0+W-1 saturated to the framebuffer edge.
  logic [XE_W-1:0]        x_sum_m1;
  logic [YE_W-1:0]        y_sum_m1;
  logic [FB_W_LOG2-1:0]   x_last_c;
  logic [FB_H_LOG2-1:0]   y_last_c;

  // Clip the registered command against the right and bottom edges.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here by
    // straight-line assignment) so no latch can be inferred.
    x_sum_m1 = XE_W'(cmd_x0) + XE_W'(cmd_w) - XE_W'(1);
    y_sum_m1 = YE_W'(cmd_y0) + YE_W'(cmd_h) - YE_W'(1);
    x_last_c = (x_sum_m1 >= X_LIM) ? '1 : x_sum_m1[FB_W_LOG2-1:0];
    y_last_c = (y_sum_m1 >= Y_LIM) ? '1 : y_sum_m1[FB_H_LOG2-1:0];
  end

`ifdef FB_CLEAR_EN
  // A clear request pre-empts command acceptance in the same cycle.
  assign oCMD_READY = ready_q & ~iCLEAR;
`else
  assign oCMD_READY = ready_q;
`endif

  // Control FSM with registered outputs; walks the clipped rectangle one pixel
  // per cycle in which the write FIFO has room.
  always_ff @(posedge iCLK) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (iRST) begin
      // NOTE: only control and output registers are reset; the command and
      // walker registers are always loaded before they are read.
      state    <= IDLE;
      ready_q  <= 1'b1;
      oWR      <= 1'b0;
      oWR_ADDR <= '0;
      oWR_DATA <= '0;
      oBUSY    <= 1'b0;
      oDONE    <= 1'b0;
    end else begin
      oWR   <= 1'b0;
      oDONE <= 1'b0;
      unique case (state)
        IDLE: begin
`ifdef FB_CLEAR_EN
          if (iCLEAR) begin
            state   <= CLR_WAIT;
            ready_q <= 1'b0;
            oBUSY   <= 1'b1;
          end else
`endif
          if (iCMD_VALID) begin
            cmd_x0    <= iCMD_X0;
            cmd_y0    <= iCMD_Y0;
            cmd_w     <= iCMD_W;
            cmd_h     <= iCMD_H;
            cmd_color <= iCMD_COLOR;
            state     <= SETUP;
            ready_q   <= 1'b0;
            oBUSY     <= 1'b1;
          end
        end

        SETUP: begin
          x_cur  <= cmd_x0;
          y_cur  <= cmd_y0;
          x_last <= x_last_c;
          y_last <= y_last_c;
          if (cmd_w == '0 || cmd_h == '0) state <= DONE;
          else if (WAIT_FRAME != 0)       state <= SYNC;
          else                            state <= DRAW;
        end

        SYNC: begin
          if (iFRAME_SYNC) state <= DRAW;
        end

`ifdef FB_CLEAR_EN
        CLR_WAIT: begin
          if (iFRAME_SYNC) begin
            cmd_x0    <= '0;
            cmd_color <= CLEAR_COLOR;
            x_cur     <= '0;
            y_cur     <= '0;
            x_last    <= '1;
            y_last    <= '1;
            state     <= CLEAR;
          end
        end

        DRAW, CLEAR: begin
`else
        DRAW: begin
`endif
          // A full FIFO freezes the walker; address/data keep the last write.
          if (!iWR_FULL) begin
            oWR      <= 1'b1;
            oWR_ADDR <= {y_cur, x_cur};
            oWR_DATA <= {1'b0, cmd_color};
            if (x_cur == x_last) begin
              x_cur <= cmd_x0;
              if (y_cur == y_last) state <= DONE;
              else                 y_cur <= y_cur + FB_H_LOG2'(1);
            end else begin
              x_cur <= x_cur + FB_W_LOG2'(1);
            end
          end
        end

        DONE: begin
          oDONE   <= 1'b1;
          oBUSY   <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
// tb_fb_rect_writer: directed bench for fb_rect_writer. A reference model
// enumerates the clipped rectangle into a queue of expected writes; a monitor
// pops one entry per observed write. Directed tasks check handshake timing.
module tb_fb_rect_writer;

  localparam logic [14:0] TB_CLEAR_COLOR = 15'h1234;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iCMD_VALID = 1'b0;
  logic        oCMD_READY;
  logic [7:0]  iCMD_X0 = '0;
  logic [7:0]  iCMD_Y0 = '0;
  logic [8:0]  iCMD_W = '0;
  logic [8:0]  iCMD_H = '0;
  logic [14:0] iCMD_COLOR = '0;
`ifdef FB_CLEAR_EN
  logic        iCLEAR = 1'b0;
`endif
  logic        iFRAME_SYNC = 1'b0;
  logic        iWR_FULL = 1'b0;
  logic        oWR;
  logic [15:0] oWR_ADDR;
  logic [15:0] oWR_DATA;
  logic        oBUSY;
  logic        oDONE;

  always #5 iCLK = ~iCLK;

  fb_rect_writer #(.CLEAR_COLOR(TB_CLEAR_COLOR)) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iCMD_VALID  (iCMD_VALID),
    .oCMD_READY  (oCMD_READY),
    .iCMD_X0     (iCMD_X0),
    .iCMD_Y0     (iCMD_Y0),
    .iCMD_W      (iCMD_W),
    .iCMD_H      (iCMD_H),
    .iCMD_COLOR  (iCMD_COLOR),
`ifdef FB_CLEAR_EN
    .iCLEAR      (iCLEAR),
`endif
    .iFRAME_SYNC (iFRAME_SYNC),
    .iWR_FULL    (iWR_FULL),
    .oWR         (oWR),
    .oWR_ADDR    (oWR_ADDR),
    .oWR_DATA    (oWR_DATA),
    .oBUSY       (oBUSY),
    .oDONE       (oDONE)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic full_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every in-bounds pixel of the rectangle, row-major, never wrapping.
  task automatic load_model(input int x0, input int y0, input int w, input int h,
                            input logic [14:0] color);
    int xe, ye;
    wr_t e;
    xe = (x0 + w > 256) ? 256 : x0 + w;
    ye = (y0 + h > 256) ? 256 : y0 + h;
    for (int y = y0; y < ye; y++) begin
      for (int x = x0; x < xe; x++) begin
        e.addr = 16'(y * 256 + x);
        e.data = {1'b0, color};
        exp_q.push_back(e);
      end
    end
  endtask

  // FIFO-full level in effect at the edge that produced the current outputs.
  always @(posedge iCLK) full_q <= iWR_FULL;

  // Monitor: each observed write must be the next expected pixel.
  always @(negedge iCLK) begin
    if (oWR === 1'b1) begin
      wr_t e;
      check("wr_while_full", {31'b0, full_q}, 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wr_unexpected: got write to 0x%0h, expected no write at %0t", oWR_ADDR, $time);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {16'b0, oWR_ADDR}, {16'b0, e.addr});
        check("wr_data", {16'b0, oWR_DATA}, {16'b0, e.data});
      end
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // Runs cycles until oDONE; c counts edges since the start event.
  task automatic wait_done(input logic [63:0] full_mask, input int budget,
                           output int nwr, output int first_c, output int done_c);
    logic [15:0] last_addr;
    nwr = 0;
    first_c = -1;
    done_c = -1;
    last_addr = '0;
    for (int c = 0; c < budget; c++) begin
      if (oWR) begin
        if (first_c < 0) first_c = c;
        nwr++;
        last_addr = oWR_ADDR;
      end else if (nwr > 0 && full_q && oBUSY) begin
        check("addr_held", {16'b0, oWR_ADDR}, {16'b0, last_addr});
      end
      if (oDONE) begin
        done_c = c;
        break;
      end
      iWR_FULL = (c < 64) ? full_mask[c] : 1'b0;
      tick();
    end
    iWR_FULL = 1'b0;
    if (done_c < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no oDONE, expected one within %0d cycles", budget);
    end else begin
      check("done_ready", {31'b0, oCMD_READY}, 32'd1);
      check("done_busy", {31'b0, oBUSY}, 32'd0);
      check("model_drained", exp_q.size(), 32'd0);
      tick();
      check("done_pulse_len", {31'b0, oDONE}, 32'd0);
    end
  endtask

  // Presents one command, then scrambles the inputs to prove they were captured.
  task automatic accept_cmd(input int x0, input int y0, input int w, input int h,
                            input logic [14:0] color);
    check("ready_before", {31'b0, oCMD_READY}, 32'd1);
    iCMD_X0 = 8'(x0);
    iCMD_Y0 = 8'(y0);
    iCMD_W = 9'(w);
    iCMD_H = 9'(h);
    iCMD_COLOR = color;
    iCMD_VALID = 1'b1;
    tick();
    iCMD_VALID = 1'b0;
    iCMD_X0 = 8'($urandom);
    iCMD_Y0 = 8'($urandom);
    iCMD_W = 9'($urandom);
    iCMD_H = 9'($urandom);
    iCMD_COLOR = 15'($urandom);
    check("ready_after_accept", {31'b0, oCMD_READY}, 32'd0);
    check("busy_after_accept", {31'b0, oBUSY}, 32'd1);
  endtask

  initial begin
    int nwr, first_c, done_c;
    bit saw_done;

    // Reset held for three cycles.
    iRST = 1'b1;
    repeat (3) tick();
    check("rst_ready", {31'b0, oCMD_READY}, 32'd1);
    check("rst_wr", {31'b0, oWR}, 32'd0);
    check("rst_busy", {31'b0, oBUSY}, 32'd0);
    check("rst_done", {31'b0, oDONE}, 32'd0);
    check("rst_addr", {16'b0, oWR_ADDR}, 32'd0);
    check("rst_data", {16'b0, oWR_DATA}, 32'd0);
    iRST = 1'b0;
    tick();
    check("idle_ready", {31'b0, oCMD_READY}, 32'd1);

    // Basic 3x2 fill.
    load_model(10, 20, 3, 2, 15'h7C00);
    check("m2_count", exp_q.size(), 32'd6);
    check("m2_first", {16'b0, exp_q[0].addr}, 32'h140A);
    check("m2_last", {16'b0, exp_q[5].addr}, 32'h150C);
    check("m2_data", {16'b0, exp_q[0].data}, 32'h7C00);
    accept_cmd(10, 20, 3, 2, 15'h7C00);
    wait_done(64'h0, 50, nwr, first_c, done_c);
    check("t2_nwr", nwr, 32'd6);
    check("t2_first_latency", first_c, 32'd2);
    check("t2_done_at", done_c, 32'd8);

    // Bottom-right corner clip.
    load_model(254, 255, 4, 3, 15'h03E0);
    check("m3_count", exp_q.size(), 32'd2);
    check("m3_a0", {16'b0, exp_q[0].addr}, 32'hFFFE);
    check("m3_a1", {16'b0, exp_q[1].addr}, 32'hFFFF);
    accept_cmd(254, 255, 4, 3, 15'h03E0);
    wait_done(64'h0, 50, nwr, first_c, done_c);
    check("t3_nwr", nwr, 32'd2);
    check("t3_done_at", done_c, 32'd4);

    // Zero width: no writes, immediate completion.
    load_model(5, 5, 0, 5, 15'h001F);
    check("m4_count", exp_q.size(), 32'd0);
    accept_cmd(5, 5, 0, 5, 15'h001F);
    wait_done(64'h0, 20, nwr, first_c, done_c);
    check("t4_nwr", nwr, 32'd0);
    check("t4_done_at", done_c, 32'd2);

    // FIFO full on draw cycles 2-4: one write, three stalls, then three writes.
    load_model(100, 50, 4, 1, 15'h5555);
    check("m5_count", exp_q.size(), 32'd4);
    accept_cmd(100, 50, 4, 1, 15'h5555);
    wait_done(64'h1C, 50, nwr, first_c, done_c);
    check("t5_nwr", nwr, 32'd4);
    check("t5_first_latency", first_c, 32'd2);
    check("t5_done_at", done_c, 32'd9);

    // Right-edge clip across two rows with alternating stalls.
    load_model(250, 10, 10, 2, 15'h2A2A);
    check("m6_count", exp_q.size(), 32'd12);
    check("m6_first", {16'b0, exp_q[0].addr}, 32'h0AFA);
    check("m6_last", {16'b0, exp_q[11].addr}, 32'h0BFF);
    accept_cmd(250, 10, 10, 2, 15'h2A2A);
    wait_done(64'hAAAA, 100, nwr, first_c, done_c);
    check("t6_nwr", nwr, 32'd12);

    // Full-width command on the last row: 256 writes, no wrap to row 0.
    load_model(0, 255, 256, 256, 15'h7FFF);
    check("m7_count", exp_q.size(), 32'd256);
    check("m7_first", {16'b0, exp_q[0].addr}, 32'hFF00);
    accept_cmd(0, 255, 256, 256, 15'h7FFF);
    wait_done(64'h0, 400, nwr, first_c, done_c);
    check("t7_nwr", nwr, 32'd256);

    // Reset mid-draw aborts: no more writes and no oDONE.
    load_model(0, 0, 200, 2, 15'h0F0F);
    accept_cmd(0, 0, 200, 2, 15'h0F0F);
    nwr = 0;
    for (int c = 0; c < 50 && nwr < 10; c++) begin
      if (oWR) nwr++;
      if (nwr < 10) tick();
    end
    check("t8_pre_abort_nwr", nwr, 32'd10);
    iRST = 1'b1;
    tick();
    exp_q.delete();
    check("t8_abort_wr", {31'b0, oWR}, 32'd0);
    check("t8_abort_busy", {31'b0, oBUSY}, 32'd0);
    iRST = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      tick();
      if (oDONE) saw_done = 1'b1;
    end
    check("t8_no_done", {31'b0, saw_done}, 32'd0);
    check("t8_ready", {31'b0, oCMD_READY}, 32'd1);

`ifdef FB_CLEAR_EN
    // Clear has priority over a simultaneous command; wait for frame sync.
    iCLEAR = 1'b1;
    iCMD_VALID = 1'b1;
    #1;
    check("clr_ready_low", {31'b0, oCMD_READY}, 32'd0);
    tick();
    iCLEAR = 1'b0;
    iCMD_VALID = 1'b0;
    check("clr_busy", {31'b0, oBUSY}, 32'd1);
    repeat (3) tick();
    load_model(0, 0, 256, 256, TB_CLEAR_COLOR);
    iFRAME_SYNC = 1'b1;
    tick();
    iFRAME_SYNC = 1'b0;
    nwr = 0;
    for (int c = 0; c < 200 && nwr < 100; c++) begin
      if (oWR) nwr++;
      if (nwr < 100) tick();
    end
    check("clr_pre_abort_nwr", nwr, 32'd100);
    iRST = 1'b1;
    tick();
    exp_q.delete();
    check("clr_abort_wr", {31'b0, oWR}, 32'd0);
    iRST = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      tick();
      if (oDONE) saw_done = 1'b1;
    end
    check("clr_no_done", {31'b0, saw_done}, 32'd0);

    // Complete clear of all 65536 addresses.
    iCLEAR = 1'b1;
    tick();
    iCLEAR = 1'b0;
    load_model(0, 0, 256, 256, TB_CLEAR_COLOR);
    check("mclr_count", exp_q.size(), 32'd65536);
    iFRAME_SYNC = 1'b1;
    tick();
    iFRAME_SYNC = 1'b0;
    wait_done(64'h0, 70000, nwr, first_c, done_c);
    check("clr_nwr", nwr, 32'd65536);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
